// File: rtl/clock_domain_export_fifo.sv
// Source side of a two-phase req/ack clock-domain crossing with a DEPTH-entry FIFO.
// Queued words are launched one per handshake; req/data leave the block straight from flops.
module clock_domain_export_fifo #(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SIZE-1:0]            data,
  input  logic                       stb,
  output logic                       ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic                       idle,
  output logic [SIZE-1:0]            handshake_data,
  output logic                       handshake_req,
  input  logic                       handshake_ack
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_EMPTY = LW'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SIZE-1:0]        mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic                   overflow_r;
  logic                   req_r;
  logic [SIZE-1:0]        data_r;

  logic ack_s;
  logic channel_free_s;
  logic push_s;
  logic pop_s;
  logic ovf_set_s;

  assign ack_s = sync_r[SYNC_STAGES-1];

  // Push/pop decisions; level is the only full/empty indicator (pointers have no wrap bit).
  always_comb begin
    channel_free_s = (ack_s == req_r);
    push_s         = stb && (level_r != LEVEL_FULL) && !flush;
    pop_s          = channel_free_s && (level_r != LEVEL_EMPTY) && !flush;
    ovf_set_s      = stb && (level_r == LEVEL_FULL);
  end

  // Synchroniser chain for the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], handshake_ack};
    end
  end

  // Storage array; written only on an accepted, non-flushed push.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Pointers, level, launch register and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      level_r    <= LEVEL_EMPTY;
      overflow_r <= 1'b0;
      req_r      <= 1'b0;
      data_r     <= SIZE'(0);
    end else begin
      if (flush) begin
        // An in-flight word is untouched; only queued words are discarded.
        rd_ptr_r <= wr_ptr_r;
        level_r  <= LEVEL_EMPTY;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
          data_r   <= mem_r[rd_ptr_r];
          req_r    <= ~req_r;
        end
        if (push_s && !pop_s) begin
          level_r <= level_r + LW'(1);
        end else if (pop_s && !push_s) begin
          level_r <= level_r - LW'(1);
        end
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (overflow_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign ready          = (level_r != LEVEL_FULL);
  assign idle           = (level_r == LEVEL_EMPTY) && channel_free_s;
  assign level          = level_r;
  assign overflow       = overflow_r;
  assign handshake_data = data_r;
  assign handshake_req  = req_r;

endmodule
